// File: rtl/prefix_add_arbiter.sv
// Round-robin arbiter in front of a shared Sklansky prefix adder.
// The winning requester's operands feed one combinational adder. The result is
// captured in a single output register and tagged with the winner's index.
module prefix_add_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [IDW-1:0]   id_q;

    logic             found;
    logic [IDW-1:0]   winner;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;
    logic             can_accept;
    logic             take;

    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_pre;
    logic [WIDTH-1:0] sum_comb;
    logic             cout_comb;

    // Output register is free when empty or being drained this cycle.
    assign can_accept = (state_q == StEmpty) || rsp_ready;

    // Round-robin search starting at ptr; also mux out the winner's operands.
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        winner  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + 32'(k)) % NREQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                winner  = IDW'(idx);
                sel_a   = req_a[idx*WIDTH +: WIDTH];
                sel_b   = req_b[idx*WIDTH +: WIDTH];
                sel_cin = req_cin[idx];
            end
        end
    end

    // Grant is withheld during reset so nothing is accepted into a clearing register.
    always_comb begin
        req_ready = '0;
        take      = found && can_accept && !reset;
        if (take) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Bit-level generate/propagate; carry-in folds into the bit-0 generate.
    assign g_in = sel_a & sel_b;
    assign p_in = sel_a ^ sel_b;

    // Sklansky prefix tree: at level l, every bit whose l-th index bit is set
    // combines with the top bit of the lower half of its 2^(l+1) block.
    always_comb begin
        logic [WIDTH-1:0] g_cur;
        logic [WIDTH-1:0] p_cur;
        logic [WIDTH-1:0] g_nxt;
        logic [WIDTH-1:0] p_nxt;
        int               j;
        g_cur    = g_in;
        g_cur[0] = g_in[0] | (p_in[0] & sel_cin);
        p_cur    = p_in;
        g_nxt    = g_cur;
        p_nxt    = p_cur;
        j        = 0;
        for (int l = 0; l < LEVELS; l++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> l) & 1) != 0) begin
                    j        = ((i >> l) << l) - 1;
                    g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[j]);
                    p_nxt[i] = p_cur[i] & p_cur[j];
                end
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        g_pre = g_cur;
    end

    // g_pre[i] is the carry into bit i+1.
    assign sum_comb  = p_in ^ {g_pre[WIDTH-2:0], sel_cin};
    assign cout_comb = g_pre[WIDTH-1];

    // Output register occupancy and round-robin pointer update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StEmpty: begin
                if (take) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (take) begin
                    state_d = StFull;
                end else if (rsp_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (take) begin
            ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
        end
    end

    // State, pointer and result registers; result loads only on a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (take) begin
                sum_q  <= sum_comb;
                cout_q <= cout_comb;
                id_q   <= winner;
            end
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;

endmodule
